// File: rtl/seq_start_arbiter.sv
// -----------------------------------------------------------------------------
// seq_start_arbiter
//
// Shares one bus sequencer between NUM_REQ independent requesters. A
// round-robin arbiter picks one requester, launches the sequencer at that
// requester's ROM start address, and holds the grant until the sequence
// completes. Resume strobes for paused programs are forwarded from the granted
// requester only. Completion is reported per requester. A launch that the
// sequencer never acknowledges is reported as an error.
//
// Ports:
//   clk_i            clock
//   rst_i            synchronous reset, active-high
//   req_i            level request per requester
//   start_addr_i     per-requester start address, slot k at [k*ADDR_W +: ADDR_W]
//   resume_i         resume pulse per requester (granted requester only)
//   grant_o          one-hot grant, or all zero
//   done_o           1-cycle completion pulse to the granted requester
//   err_o            1-cycle launch-timeout flag, coincident with done_o
//   busy_o           high from grant to completion
//   seq_start_o      sequencer start/resume strobe
//   seq_start_addr_o start address latched at grant time
//   seq_ready_i      sequencer ready (high = sequencer idle)
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module seq_start_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int ADDR_W      = 8,
   parameter int ACK_TIMEOUT = 16
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [NUM_REQ-1:0]        req_i,
   input  logic [NUM_REQ*ADDR_W-1:0] start_addr_i,
   input  logic [NUM_REQ-1:0]        resume_i,
   output logic [NUM_REQ-1:0]        grant_o,
   output logic [NUM_REQ-1:0]        done_o,
   output logic                      err_o,
   output logic                      busy_o,
   output logic                      seq_start_o,
   output logic [ADDR_W-1:0]         seq_start_addr_o,
   input  logic                      seq_ready_i
);

   localparam int                 IDX_W    = $clog2(NUM_REQ);
   localparam int                 CNT_W    = $clog2(ACK_TIMEOUT);
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
   localparam logic [IDX_W-1:0]   PTR_INIT = IDX_W'(NUM_REQ - 1);
   localparam logic [IDX_W:0]     REQ_CNT  = (IDX_W + 1)'(NUM_REQ);

   typedef enum logic [1:0] {
      IDLE,
      LAUNCH,
      RUN,
      FINISH
   } state_t;

   state_t             state, state_next;
   logic [IDX_W-1:0]   ptr, ptr_next;
   logic [IDX_W-1:0]   gnt_idx, gnt_idx_next;
   logic [CNT_W-1:0]   cnt, cnt_next;

   logic [NUM_REQ-1:0] grant_next;
   logic [NUM_REQ-1:0] done_next;
   logic               err_next;
   logic               busy_next;
   logic               start_next;
   logic [ADDR_W-1:0]  addr_next;

   logic               pick_valid;
   logic [IDX_W-1:0]   pick_idx;
   logic [IDX_W:0]     cand_sum;
   logic [IDX_W-1:0]   cand;
   logic [ADDR_W-1:0]  addr_slot [NUM_REQ];

   // Unpack the flat address bus so the winner's slot is a simple array index.
   always_comb begin
      for (int k = 0; k < NUM_REQ; k++) begin
         addr_slot[k] = start_addr_i[k*ADDR_W +: ADDR_W];
      end
   end

   // Round-robin search: first set request starting just above the last
   // winner, wrapping at NUM_REQ (which need not be a power of two).
   always_comb begin
      // NOTE: every combinational output gets a default before any branch so
      // no path leaves it unassigned and no latch is inferred.
      pick_valid = 1'b0;
      pick_idx   = '0;
      cand_sum   = '0;
      cand       = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand_sum = {1'b0, ptr} + (IDX_W + 1)'(i);
         if (cand_sum >= REQ_CNT) begin
            cand_sum = cand_sum - REQ_CNT;
         end
         cand = cand_sum[IDX_W-1:0];
         if (!pick_valid && req_i[cand]) begin
            pick_valid = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   // Next-state and next-output logic. Outputs hold by default except the
   // single-cycle pulses (done, err, start strobe), which default low.
   always_comb begin
      state_next   = state;
      ptr_next     = ptr;
      gnt_idx_next = gnt_idx;
      cnt_next     = cnt;
      grant_next   = grant_o;
      done_next    = '0;
      err_next     = 1'b0;
      busy_next    = busy_o;
      start_next   = 1'b0;
      addr_next    = seq_start_addr_o;

      unique case (state)
         IDLE: begin
            if (pick_valid) begin
               gnt_idx_next         = pick_idx;
               grant_next           = '0;
               grant_next[pick_idx] = 1'b1;
               busy_next            = 1'b1;
               start_next           = 1'b1;
               addr_next            = addr_slot[pick_idx];
               cnt_next             = '0;
               state_next           = LAUNCH;
            end
         end

         LAUNCH: begin
            // Ready falling wins over a timeout reached in the same cycle.
            if (!seq_ready_i) begin
               cnt_next   = '0;
               state_next = RUN;
            end else if (cnt == CNT_LAST) begin
               done_next  = grant_o;
               err_next   = 1'b1;
               state_next = FINISH;
            end else begin
               start_next = 1'b1;
               cnt_next   = cnt + 1'b1;
            end
         end

         RUN: begin
            if (seq_ready_i) begin
               done_next  = grant_o;
               state_next = FINISH;
            end else if (resume_i[gnt_idx] && !seq_start_o) begin
               // A resume arriving while the previous strobe is high is dropped.
               start_next = 1'b1;
            end
         end

         FINISH: begin
            grant_next = '0;
            busy_next  = 1'b0;
            ptr_next   = gnt_idx;
            state_next = IDLE;
         end

         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values, independent of statement order.
      if (rst_i) begin
         state            <= IDLE;
         ptr              <= PTR_INIT;
         gnt_idx          <= '0;
         cnt              <= '0;
         grant_o          <= '0;
         done_o           <= '0;
         err_o            <= 1'b0;
         busy_o           <= 1'b0;
         seq_start_o      <= 1'b0;
         seq_start_addr_o <= '0;
      end else begin
         state            <= state_next;
         ptr              <= ptr_next;
         gnt_idx          <= gnt_idx_next;
         cnt              <= cnt_next;
         grant_o          <= grant_next;
         done_o           <= done_next;
         err_o            <= err_next;
         busy_o           <= busy_next;
         seq_start_o      <= start_next;
         seq_start_addr_o <= addr_next;
      end
   end

endmodule

// File: tb/tb_seq_start_arbiter.sv
// -----------------------------------------------------------------------------
// tb_seq_start_arbiter
//
// Self-checking bench for seq_start_arbiter. The bench plays the requesters and
// the sequencer. Each sequence is described by its request vector, the number
// of cycles the sequencer keeps ready high after the launch strobe (ack delay),
// and the number of busy cycles. Expected outputs for every cycle come from a
// transaction-level model: a round-robin pick over the request vector, launch
// strobe length min(delay+1, ACK_TIMEOUT), and a resume rule applied to the
// granted requester only.
// -----------------------------------------------------------------------------
module tb_seq_start_arbiter;

   localparam int NUM_REQ     = 4;
   localparam int ADDR_W      = 8;
   localparam int ACK_TIMEOUT = 16;

   logic                      clk = 1'b0;
   logic                      rst;
   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ*ADDR_W-1:0] start_addr;
   logic [NUM_REQ-1:0]        resume;
   logic [NUM_REQ-1:0]        grant;
   logic [NUM_REQ-1:0]        done;
   logic                      err;
   logic                      busy;
   logic                      seq_start;
   logic [ADDR_W-1:0]         seq_addr;
   logic                      seq_ready;

   // Expected outputs for the next observed cycle.
   logic [NUM_REQ-1:0]        e_grant;
   logic [NUM_REQ-1:0]        e_done;
   logic                      e_err;
   logic                      e_busy;
   logic                      e_start;
   logic [ADDR_W-1:0]         e_addr;

   int ptr_m;        // last winner as seen by the model
   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   seq_start_arbiter #(
      .NUM_REQ    (NUM_REQ),
      .ADDR_W     (ADDR_W),
      .ACK_TIMEOUT(ACK_TIMEOUT)
   ) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .req_i           (req),
      .start_addr_i    (start_addr),
      .resume_i        (resume),
      .grant_o         (grant),
      .done_o          (done),
      .err_o           (err),
      .busy_o          (busy),
      .seq_start_o     (seq_start),
      .seq_start_addr_o(seq_addr),
      .seq_ready_i     (seq_ready)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Advance one clock and compare every output 1 time unit after the edge.
   task automatic cyc();
      @(posedge clk);
      #1;
      check("grant",          32'(grant),     32'(e_grant));
      check("busy",           32'(busy),      32'(e_busy));
      check("seq_start",      32'(seq_start), 32'(e_start));
      check("done",           32'(done),      32'(e_done));
      check("err",            32'(err),       32'(e_err));
      check("seq_start_addr", 32'(seq_addr),  32'(e_addr));
   endtask

   function automatic int rr_pick(input logic [NUM_REQ-1:0] r, input int p);
      int idx;
      for (int i = 1; i <= NUM_REQ; i++) begin
         idx = (p + i) % NUM_REQ;
         if (r[idx]) return idx;
      end
      return -1;
   endfunction

   function automatic logic [NUM_REQ*ADDR_W-1:0] rand_addrs();
      logic [NUM_REQ*ADDR_W-1:0] v;
      for (int k = 0; k < NUM_REQ; k++) begin
         v[k*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
      end
      return v;
   endfunction

   // Resume pattern for the pause test (requester 2 granted): requester 2
   // holds resume for two cycles, requester 1 pulses twice later.
   function automatic logic [NUM_REQ-1:0] pause_pattern(input int i);
      logic [NUM_REQ-1:0] v;
      v = '0;
      if (i == 1 || i == 2) v[2] = 1'b1;
      if (i == 3 || i == 5) v[1] = 1'b1;
      return v;
   endfunction

   task automatic scramble();
      req        = NUM_REQ'($urandom);
      start_addr = rand_addrs();
   endtask

   task automatic expect_idle();
      e_grant = '0;
      e_busy  = 1'b0;
      e_start = 1'b0;
      e_done  = '0;
      e_err   = 1'b0;
   endtask

   task automatic idle_cycles(input int k);
      req = '0;
      expect_idle();
      for (int i = 0; i < k; i++) begin
         resume = NUM_REQ'($urandom);
         cyc();
      end
   endtask

   // One complete sequence, entered and left on an IDLE cycle.
   //   a   : cycles the sequencer keeps ready high after the strobe (>= ACK_TIMEOUT -> timeout)
   //   len : cycles the sequencer stays busy once ready has fallen (>= 1)
   task automatic run_episode(
      input  logic [NUM_REQ-1:0]        r,
      input  logic [NUM_REQ*ADDR_W-1:0] addrs,
      input  int                        a,
      input  int                        len,
      input  bit                        noise,
      input  bit                        pause_test,
      output logic [NUM_REQ-1:0]        first_grant,
      output int                        pulses
   );
      int                 w;
      int                 strobe_len;
      int                 dones;
      bit                 timed_out;
      logic [NUM_REQ-1:0] g;

      pulses     = 0;
      strobe_len = 0;
      dones      = 0;
      timed_out  = (a >= ACK_TIMEOUT);
      w          = rr_pick(r, ptr_m);
      g          = '0;
      g[w]       = 1'b1;

      req        = r;
      start_addr = addrs;
      seq_ready  = 1'b1;
      resume     = pause_test ? '0 : NUM_REQ'($urandom);
      e_grant    = g;
      e_busy     = 1'b1;
      e_start    = 1'b1;
      e_done     = '0;
      e_err      = 1'b0;
      e_addr     = addrs[w*ADDR_W +: ADDR_W];
      cyc();
      first_grant = grant;
      strobe_len += int'(seq_start);

      // Launch: ready stays high for a cycles, then falls (unless timed out).
      for (int c = 0; c <= a && c < ACK_TIMEOUT; c++) begin
         seq_ready = (c < a);
         if (noise) scramble();
         resume = pause_test ? '0 : NUM_REQ'($urandom);
         if (c == a) begin
            e_start = 1'b0;
         end else if (c == ACK_TIMEOUT - 1) begin
            e_start = 1'b0;
            e_done  = g;
            e_err   = 1'b1;
         end
         cyc();
         strobe_len += int'(seq_start);
         if (done != '0) dones++;
      end
      check("launch_len", strobe_len, timed_out ? ACK_TIMEOUT : a + 1);

      if (!timed_out) begin
         // Run: a granted resume seen while the strobe is low yields one strobe.
         for (int i = 0; i < len - 1; i++) begin
            seq_ready = 1'b0;
            if (noise) scramble();
            resume  = pause_test ? pause_pattern(i) : NUM_REQ'($urandom);
            e_start = !e_start && resume[w];
            cyc();
            pulses += int'(seq_start);
            if (done != '0) dones++;
         end
         // Sequencer returns to idle: completion, any pending resume discarded.
         seq_ready = 1'b1;
         if (noise) scramble();
         resume  = pause_test ? '0 : NUM_REQ'($urandom);
         e_start = 1'b0;
         e_done  = g;
         e_err   = 1'b0;
         cyc();
         if (done != '0) dones++;
      end

      // Grant released; winner becomes lowest priority.
      ptr_m = w;
      expect_idle();
      if (noise) scramble();
      resume = pause_test ? '0 : NUM_REQ'($urandom);
      cyc();
      if (done != '0) dones++;
      check("done_count", dones, 1);
   endtask

   initial begin
      logic [NUM_REQ-1:0]        fg;
      logic [NUM_REQ*ADDR_W-1:0] addrs;
      logic [NUM_REQ-1:0]        r;
      int                        p;
      int                        a;
      int                        len;
      int                        sel;
      bit                        noise;

      rst        = 1'b1;
      req        = '0;
      start_addr = '0;
      resume     = '0;
      seq_ready  = 1'b1;
      ptr_m      = NUM_REQ - 1;
      e_addr     = '0;
      expect_idle();

      // Reset state.
      cyc();
      cyc();
      rst = 1'b0;

      // Round-robin with every request held: order 0,1,2,3,0.
      for (int i = 0; i < 5; i++) begin
         run_episode('1, rand_addrs(), 2, 3, 1'b0, 1'b0, fg, p);
         check("rr_order", 32'(fg), 32'(NUM_REQ'(1) << (i % NUM_REQ)));
      end

      // Single requester at address 0x20, ready falls after 2, busy for 10.
      addrs              = rand_addrs();
      addrs[ADDR_W-1:0]  = 8'h20;
      run_episode(NUM_REQ'(1), addrs, 2, 10, 1'b0, 1'b0, fg, p);
      check("single_grant", 32'(fg), 32'(1));

      // Pause/resume: requester 2 granted, foreign resumes ignored.
      run_episode(NUM_REQ'(4), rand_addrs(), 1, 8, 1'b0, 1'b1, fg, p);
      check("pause_grant", 32'(fg), 32'(4));
      check("pause_pulses", p, 1);

      // Launch timeout, then a normal sequence, then ready falling exactly on
      // the timeout cycle (ready wins).
      run_episode(NUM_REQ'(8), rand_addrs(), ACK_TIMEOUT + 3, 4, 1'b0, 1'b0, fg, p);
      run_episode('1, rand_addrs(), 0, 3, 1'b0, 1'b0, fg, p);
      run_episode(NUM_REQ'(2), rand_addrs(), ACK_TIMEOUT - 1, 2, 1'b0, 1'b0, fg, p);

      // Withdrawal and address changes after the grant.
      run_episode(NUM_REQ'(2), rand_addrs(), 1, 6, 1'b1, 1'b0, fg, p);
      check("withdraw_grant", 32'(fg), 32'(2));

      // Reset in the middle of RUN.
      addrs      = rand_addrs();
      req        = NUM_REQ'(2);
      start_addr = addrs;
      seq_ready  = 1'b1;
      resume     = '0;
      e_grant    = NUM_REQ'(2);
      e_busy     = 1'b1;
      e_start    = 1'b1;
      e_done     = '0;
      e_err      = 1'b0;
      e_addr     = addrs[ADDR_W +: ADDR_W];
      cyc();
      seq_ready = 1'b0;
      e_start   = 1'b0;
      cyc();
      req     = '0;
      resume  = NUM_REQ'(2);
      e_start = 1'b1;
      cyc();
      resume  = '0;
      e_start = 1'b0;
      cyc();
      rst    = 1'b1;
      expect_idle();
      e_addr = '0;
      cyc();
      rst       = 1'b0;
      seq_ready = 1'b1;
      ptr_m     = NUM_REQ - 1;
      cyc();
      cyc();
      run_episode('1, rand_addrs(), 0, 2, 1'b0, 1'b0, fg, p);
      check("post_reset_grant", 32'(fg), 32'(1));

      // Randomized sequences.
      for (int ep = 0; ep < 40; ep++) begin
         if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
         r   = NUM_REQ'($urandom_range(1, 2**NUM_REQ - 1));
         sel = $urandom_range(0, 9);
         if (sel == 0)      a = ACK_TIMEOUT + $urandom_range(0, 4);
         else if (sel == 1) a = ACK_TIMEOUT - 1;
         else               a = $urandom_range(0, 4);
         len   = $urandom_range(1, 8);
         noise = 1'($urandom_range(0, 1));
         run_episode(r, rand_addrs(), a, len, noise, 1'b0, fg, p);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: summary not reached at %0t", $time);
      $fatal(1);
   end

endmodule

// File: doc/seq_start_arbiter.md
Name: seq_start_arbiter

Overview:
- Shares one bus sequencer between NUM_REQ independent requesters, for example CPU mailbox, trigger input and self-test.
- Each requester supplies its own ROM program start address.
- Round-robin arbitration selects one requester, launches the sequencer, and holds the grant until the sequence finishes.
- Forwards resume pulses for programs that contain PAUSE, and reports completion or launch timeout per requester.
- Sits between the requesters and the sequencer's start/ready/start-address interface.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- ADDR_W, 8: ROM start-address width.
- ACK_TIMEOUT, 16: cycles seq_start_o may stay high without the sequencer dropping ready before a launch error is declared, >=2.

Ports:
- clk_i  in  1: clock.
- rst_i  in  1: synchronous reset, active-high.
- req_i  in  NUM_REQ: level request per requester.
- start_addr_i  in  NUM_REQ*ADDR_W: program start address; requester k occupies bits [k*ADDR_W +: ADDR_W].
- resume_i  in  NUM_REQ: resume pulse per requester; honoured only from the granted requester.
- grant_o  out  NUM_REQ: one-hot grant, or all zero.
- done_o  out  NUM_REQ: 1-cycle completion pulse to the granted requester.
- err_o  out  1: 1-cycle pulse, coincident with done_o, when the launch timed out.
- busy_o  out  1: high from grant to completion.
- seq_start_o  out  1: sequencer start/resume strobe.
- seq_start_addr_o  out  ADDR_W: latched start address of the granted requester.
- seq_ready_i  in  1: sequencer ready (high = IDLE).

Behaviour:
- Reset values: grant_o, done_o, err_o, busy_o, seq_start_o all 0; seq_start_addr_o 0; rr pointer = NUM_REQ-1, so requester 0 has highest priority first; state IDLE; timeout counter 0.
- All outputs are registered.
- State IDLE:
  - If any req_i bit is high, pick the first set bit searching (ptr+1) mod NUM_REQ upward with wrap.
  - Next cycle: grant_o one-hot, busy_o=1, seq_start_o=1, seq_start_addr_o latched from that requester's slice. Go to LAUNCH. Latency from req to seq_start_o is 1 cycle.
  - If no request, stay in IDLE.
- State LAUNCH:
  - seq_start_o held high; timeout counter increments each cycle.
  - seq_ready_i==0: deassert seq_start_o next cycle, clear counter, go to RUN.
  - Counter reaches ACK_TIMEOUT-1 with seq_ready_i still 1: deassert seq_start_o and go to FINISH with error flag set.
  - If ready falls on the same cycle the timeout is reached, ready wins (no error).
- State RUN:
  - resume_i[g]==1 for granted index g while seq_start_o==0 and seq_ready_i==0: seq_start_o=1 for exactly one cycle.
  - A resume arriving while that pulse is still high is dropped.
  - resume_i on non-granted indices is ignored.
  - seq_ready_i==1: go to FINISH. Any pending resume pulse is not issued, and seq_start_o is forced 0.
- State FINISH (one cycle):
  - done_o[g]=1, and err_o = error flag.
  - Next cycle: grant_o=0, busy_o=0, ptr=g, error flag cleared, go to IDLE.
  - New arbitration may be evaluated in that IDLE cycle, so the minimum gap between grants is 2 cycles.
- Grant is never revoked. Dropping req_i[g] during LAUNCH or RUN has no effect, because the sequencer has no abort. A requester that still holds req_i after done_o re-competes at lowest priority.
- Changes to start_addr_i after the grant are ignored; the address is latched once.
- seq_start_o is never high in IDLE or FINISH.
- Reset mid-operation: everything returns to reset values next cycle with no done_o or err_o emitted. The sequencer is reset by its own reset.

Test Plan:
- Single requester: req_i=0001, start_addr[0]=0x20; sequencer model drops ready 2 cycles after start and raises it 10 cycles later -> grant_o=0001 and seq_start_o=1 at cycle+1 with addr 0x20, seq_start_o low the cycle after ready falls, done_o=0001 one cycle after ready rises, err_o=0.
- Round-robin: req_i=1111 held for 5 sequences -> grant order 0,1,2,3,0; exactly one done_o per sequence; grants never overlap.
- Pause/resume: granted requester 2 pulses resume_i[2] in RUN, requester 1 pulses resume_i[1] -> exactly one 1-cycle seq_start_o, for requester 2 only.
- Launch timeout: seq_ready_i stuck at 1, ACK_TIMEOUT=16 -> seq_start_o high 16 cycles then low, done_o and err_o pulse together, next request is granted normally.
- Request withdrawal plus late address change: req_i[1] drops and start_addr[1] changes during RUN -> grant held, seq_start_addr_o unchanged, done_o[1] still pulses.
- Reset mid-RUN: assert rst_i for 1 cycle -> all outputs 0 the following cycle, no done_o; next arbitration starts from requester 0.
